// File: rtl/fp_pkg.sv
// Shared single-precision definitions: FSM states, field widths, special
// encodings and an operand unpack helper.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_EXEC,
    S_NORM,
    S_PACK
  } state_e;

  // Operand split into fields; man carries the hidden bit and is zero for
  // zero/denormal encodings, which are flushed to signed zero.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  function automatic fp_unpacked_t fp_unpack(input logic [31:0] w);
    fp_unpacked_t u;
    u.sign    = w[31];
    u.exp     = w[30:23];
    u.is_zero = (w[30:23] == '0);
    u.is_inf  = (w[30:23] == '1) && (w[22:0] == '0);
    u.is_nan  = (w[30:23] == '1) && (w[22:0] != '0);
    u.man     = u.is_zero ? '0 : {1'b1, w[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_alu_seq_if.sv
// Request/response bundle between the core controller and the FP unit.
interface fp_alu_seq_if;

  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flags
  );

endinterface

// File: rtl/fp_lzc.sv
// 48-bit leading-zero counter; an all-zero input reports 48.
module fp_lzc (
  input  logic [47:0] val,
  output logic [5:0]  cnt
);

  // Scan upward so the most significant set bit is the last one written.
  always_comb begin
    cnt = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (val[i]) cnt = 6'(47 - i);
    end
  end

endmodule

// File: rtl/fp_alu_seq.sv
// Multi-cycle IEEE-754 single-precision add/multiply unit, round toward zero.
// Multiply retires MUL_K multiplier bits per EXEC cycle (MUL_K divides 24).
module fp_alu_seq
  import fp_pkg::*;
#(
  parameter int MUL_K = 1
) (
  input  logic        clk,
  input  logic        reset,
  fp_alu_seq_if.slave bus
);

  localparam int ITERS = 24 / MUL_K;
  localparam int PP_W  = 24 + MUL_K;

  state_e       state, state_nxt;
  logic [4:0]   iter;
  logic         last_iter, busy, accept, finish;

  logic [31:0]  a_q, b_q;
  logic         op_q;
  fp_unpacked_t ua, ub;

  logic         a_big, big_sign;
  logic [7:0]   big_exp, sml_exp, ediff;
  logic [23:0]  big_man, sml_man;
  logic [25:0]  sml_sh;
  logic         sml_stk;
  logic         spec_hit;
  logic [31:0]  spec_val;

  logic         spec_q, sign_q, sub_q;
  logic [31:0]  spec_res_q;
  logic signed [10:0] exp_q;
  logic [26:0]  big_q, sml_q;
  logic [27:0]  sum_q;
  logic [23:0]  ma_q;
  logic [47:0]  prod_q, prod_nxt;
  logic [PP_W-1:0] pp_sum;

  logic [47:0]  norm_val;
  logic [5:0]   lz;
  logic signed [10:0] exp_n;
  logic [22:0]  man_n;
  logic [31:0]  res_nxt, res_q;
  logic         ovf_nxt, ovf_q;

  logic         done_q;
  logic [31:0]  result_q;
  logic [3:0]   flags_q;

  assign last_iter = (iter == 5'(ITERS - 1));

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one pass per stage, EXEC repeats for multiply.
  // NOTE: the default assignment up front keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = S_EXEC;
      S_EXEC:   if (!op_q || last_iter) state_nxt = S_NORM;
      S_NORM:   state_nxt = S_PACK;
      S_PACK:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy, request acceptance and completion strobe.
  always_comb begin
    busy   = (state != S_IDLE);
    accept = (state == S_IDLE) && bus.start;
    finish = (state == S_PACK);
  end

  // Multiply iteration counter; held at zero outside multiply EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                iter <= '0;
    else if (state == S_EXEC && op_q && !last_iter) iter <= iter + 5'd1;
    else                                       iter <= '0;
  end

  // Operand decode, special-case detection and add alignment.
  always_comb begin
    ua = fp_unpack(a_q);
    ub = fp_unpack(b_q);

    a_big    = {ua.exp, ua.man} >= {ub.exp, ub.man};
    big_sign = a_big ? ua.sign : ub.sign;
    big_exp  = a_big ? ua.exp  : ub.exp;
    big_man  = a_big ? ua.man  : ub.man;
    sml_exp  = a_big ? ub.exp  : ua.exp;
    sml_man  = a_big ? ub.man  : ua.man;
    ediff    = big_exp - sml_exp;

    // Large shifts leave only the sticky bit behind.
    sml_sh  = '0;
    sml_stk = |sml_man;
    if (ediff < 8'd26) begin
      sml_sh  = {sml_man, 2'b00} >> ediff;
      sml_stk = |({sml_man, 2'b00} & ~({26{1'b1}} << ediff));
    end

    spec_hit = 1'b0;
    spec_val = '0;
    if (ua.is_nan || ub.is_nan) begin
      spec_hit = 1'b1;
      spec_val = QNAN;
    end else if (op_q) begin
      if ((ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
        spec_hit = 1'b1;
        spec_val = QNAN;
      end else if (ua.is_inf || ub.is_inf) begin
        spec_hit = 1'b1;
        spec_val = {ua.sign ^ ub.sign, POS_INF[30:0]};
      end else if (ua.is_zero || ub.is_zero) begin
        spec_hit = 1'b1;
        spec_val = {ua.sign ^ ub.sign, 31'b0};
      end
    end else begin
      if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
        spec_hit = 1'b1;
        spec_val = QNAN;
      end else if (ua.is_inf) begin
        spec_hit = 1'b1;
        spec_val = {ua.sign, POS_INF[30:0]};
      end else if (ub.is_inf) begin
        spec_hit = 1'b1;
        spec_val = {ub.sign, POS_INF[30:0]};
      end else if (ua.is_zero && ub.is_zero) begin
        spec_hit = 1'b1;
        spec_val = {ua.sign & ub.sign, 31'b0};
      end
    end
  end

  // One shift-add step: add multiplicand times the low MUL_K multiplier bits
  // into the upper half, then shift the whole product register right.
  always_comb begin
    pp_sum   = PP_W'(prod_q[47:24]) + PP_W'(ma_q) * PP_W'(prod_q[MUL_K-1:0]);
    prod_nxt = 48'({pp_sum, prod_q[23:0]} >> MUL_K);
  end

  // Both paths present a value whose bit 46 weighs 2^0 at exponent exp_q-1.
  always_comb begin
    norm_val = op_q ? prod_q : {sum_q, 20'b0};
  end

  fp_lzc u_lzc (
    .val (norm_val),
    .cnt (lz)
  );

  // Normalise, truncate and classify the finite result.
  always_comb begin
    exp_n   = exp_q - $signed({5'b0, lz});
    man_n   = 23'((norm_val << lz) >> 24);
    res_nxt = {sign_q, exp_n[7:0], man_n};
    ovf_nxt = 1'b0;
    if (spec_q) begin
      res_nxt = spec_res_q;
    end else if (norm_val == '0) begin
      res_nxt = '0;
    end else if (exp_n >= 11'sd255) begin
      res_nxt = {sign_q, POS_INF[30:0]};
      ovf_nxt = 1'b1;
    end else if (exp_n <= 11'sd0) begin
      res_nxt = '0;
    end
  end

  // Datapath pipeline registers, loaded stage by stage.
  // NOTE: these carry no reset; each is written by an earlier stage before
  // any later stage reads it, and the FSM alone decides what is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
    if (state == S_UNPACK) begin
      spec_q     <= spec_hit;
      spec_res_q <= spec_val;
      ma_q       <= ua.man;
      prod_q     <= {24'b0, ub.man};
      big_q      <= {big_man, 3'b000};
      sml_q      <= {sml_sh, sml_stk};
      sub_q      <= ua.sign ^ ub.sign;
      if (op_q) begin
        sign_q <= ua.sign ^ ub.sign;
        exp_q  <= $signed(11'(ua.exp) + 11'(ub.exp) - 11'(BIAS - 1));
      end else begin
        sign_q <= big_sign;
        exp_q  <= $signed(11'(big_exp) + 11'd1);
      end
    end
    if (state == S_EXEC) begin
      if (op_q) prod_q <= prod_nxt;
      else      sum_q  <= sub_q ? ({1'b0, big_q} - {1'b0, sml_q})
                                : ({1'b0, big_q} + {1'b0, sml_q});
    end
    if (state == S_NORM) begin
      res_q <= res_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // Architectural outputs: done pulse and held result/flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0100;
    end else begin
      done_q <= finish;
      if (finish) begin
        result_q <= res_q;
        flags_q  <= {res_q[31], ~|res_q[30:0], 1'b0, ovf_q};
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed scoreboard bench for fp_alu_seq (MUL_K = 1 and MUL_K = 4).
module tb_fp_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t_start = 0;
  int   extra;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_alu_seq_if bus1 ();
  fp_alu_seq_if bus4 ();

  fp_alu_seq #(.MUL_K(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));
  fp_alu_seq #(.MUL_K(4)) dut4 (.clk(clk), .reset(rst_n), .bus(bus4.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input bit k4, input logic s, input logic o,
                        input logic [31:0] a, input logic [31:0] b);
    if (k4) begin
      bus4.start = s; bus4.op = o; bus4.a = a; bus4.b = b;
    end else begin
      bus1.start = s; bus1.op = o; bus1.a = a; bus1.b = b;
    end
  endtask

  function automatic logic obs_busy(input bit k4);
    return k4 ? bus4.busy : bus1.busy;
  endfunction

  function automatic logic obs_done(input bit k4);
    return k4 ? bus4.done : bus1.done;
  endfunction

  // Push the expectation, present the request for one edge, confirm busy.
  task automatic issue(input bit k4, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input string tag,
                       input logic [31:0] res, input logic [3:0] flg, input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.flg = flg; e.lat = lat;
    sb.push_back(e);
    set_in(k4, 1'b1, o, a, b);
    @(posedge clk); #1;
    t_start = cyc;
    set_in(k4, 1'b0, o, a, b);
    check({tag, "_busy"}, 32'(obs_busy(k4)), 32'd1);
  endtask

  // Wait (bounded) for done, pop the oldest expectation and compare.
  task automatic wait_done(input bit k4);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = obs_done(k4);
    end
    check({e.tag, "_done_seen"}, 32'(seen), 32'd1);
    check({e.tag, "_latency"}, 32'(cyc - t_start), 32'(e.lat));
    check({e.tag, "_result"}, k4 ? bus4.result : bus1.result, e.res);
    check({e.tag, "_flags"}, 32'(k4 ? bus4.flags : bus1.flags), 32'(e.flg));
    check({e.tag, "_busy_low"}, 32'(obs_busy(k4)), 32'd0);
  endtask

  task automatic run(input bit k4, input logic o, input logic [31:0] a,
                     input logic [31:0] b, input string tag,
                     input logic [31:0] res, input logic [3:0] flg, input int lat);
    issue(k4, o, a, b, tag, res, flg, lat);
    wait_done(k4);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(bus1.busy),  32'd0);
    check("rst_done",     32'(bus1.done),  32'd0);
    check("rst_result",   bus1.result,     32'h0);
    check("rst_flags",    32'(bus1.flags), 32'h4);
    check("rst_k4_flags", 32'(bus4.flags), 32'h4);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add / multiply and latency.
    run(1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, "add_1p2",   32'h4040_0000, 4'b0000, 4);
    run(1'b0, 1'b1, 32'h3FC0_0000, 32'h4000_0000, "mul_k1",    32'h4040_0000, 4'b0000, 27);
    run(1'b1, 1'b1, 32'h3FC0_0000, 32'h4000_0000, "mul_k4",    32'h4040_0000, 4'b0000, 9);
    run(1'b1, 1'b1, 32'h4040_0000, 32'h4040_0000, "mul_k4_9",  32'h4110_0000, 4'b0000, 9);

    // Cancellation, specials, overflow, underflow.
    run(1'b0, 1'b0, 32'h3F80_0000, 32'hBF80_0000, "add_cancel", 32'h0000_0000, 4'b0100, 4);
    run(1'b0, 1'b1, 32'h7F80_0000, 32'h0000_0000, "mul_inf0",   32'h7FC0_0000, 4'b0000, 27);
    run(1'b0, 1'b1, 32'h7F00_0000, 32'h7F00_0000, "mul_ovf",    32'h7F80_0000, 4'b0001, 27);
    run(1'b0, 1'b1, 32'hFF00_0000, 32'h7F00_0000, "mul_novf",   32'hFF80_0000, 4'b1001, 27);
    run(1'b0, 1'b1, 32'h0080_0000, 32'h0080_0000, "mul_unf",    32'h0000_0000, 4'b0100, 27);
    run(1'b0, 1'b1, 32'hBFC0_0000, 32'h4000_0000, "mul_neg",    32'hC040_0000, 4'b1000, 27);
    run(1'b0, 1'b1, 32'h8000_0000, 32'h3F80_0000, "mul_nzero",  32'h8000_0000, 4'b1100, 27);
    run(1'b0, 1'b0, 32'h7FC0_0001, 32'h3F80_0000, "add_nan",    32'h7FC0_0000, 4'b0000, 4);
    run(1'b0, 1'b0, 32'h7F80_0000, 32'hFF80_0000, "add_infinf", 32'h7FC0_0000, 4'b0000, 4);
    run(1'b0, 1'b0, 32'hFF80_0000, 32'h3F80_0000, "add_ninf",   32'hFF80_0000, 4'b1000, 4);
    run(1'b0, 1'b0, 32'h0000_0001, 32'h3F80_0000, "add_denorm", 32'h3F80_0000, 4'b0000, 4);

    // Alignment, sticky and truncation.
    run(1'b0, 1'b0, 32'h3F80_0000, 32'hB380_0000, "add_sub24",  32'h3F7F_FFFF, 4'b0000, 4);
    run(1'b0, 1'b0, 32'h3F80_0000, 32'hB280_0000, "add_stk26",  32'h3F7F_FFFF, 4'b0000, 4);
    run(1'b0, 1'b0, 32'h3F80_0000, 32'h3280_0000, "add_trunc",  32'h3F80_0000, 4'b0000, 4);

    // Start accepted in the done cycle.
    run(1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, "add_first",  32'h4040_0000, 4'b0000, 4);
    run(1'b0, 1'b0, 32'h40A0_0000, 32'hC040_0000, "add_b2b",    32'h4000_0000, 4'b0000, 4);

    // Start while busy is ignored; one done pulse, result holds.
    issue(1'b0, 1'b1, 32'h3FC0_0000, 32'h4000_0000, "mul_busy", 32'h4040_0000, 4'b0000, 27);
    set_in(1'b0, 1'b1, 1'b0, 32'h7F00_0000, 32'h7F00_0000);
    repeat (5) @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done(1'b0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus1.done) extra++;
    end
    check("busy_extra_done",  32'(extra),  32'd0);
    check("busy_hold_result", bus1.result, 32'h4040_0000);
    check("busy_hold_flags",  32'(bus1.flags), 32'h0);

    // Reset in cycle 10 of a multiply aborts it.
    set_in(1'b0, 1'b1, 1'b1, 32'h3FC0_0000, 32'h4000_0000);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus1.busy),  32'd0);
    check("abort_done",   32'(bus1.done),  32'd0);
    check("abort_result", bus1.result,     32'h0);
    check("abort_flags",  32'(bus1.flags), 32'h4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus1.done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);

    // Unit recovers after the abort.
    run(1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, "add_after_rst", 32'h4040_0000, 4'b0000, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_alu_seq.md
FP_ALU_SEQ -- requirements
Module: fp_alu_seq

Interface
REQ-001 SHALL have parameter MUL_K, default 1, meaning multiplier bits retired per iteration; legal values are 1, 2, 3, 4, 6, 8, 12 and 24.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled in IDLE only.
REQ-005 SHALL have port op, input, 1 bit: 0 = add, 1 = multiply; driven by the decoder's ALUControl[0].
REQ-006 SHALL have port a, input, 32 bits: IEEE-754 single operand, taken from SrcA.
REQ-007 SHALL have port b, input, 32 bits: IEEE-754 single operand, taken from SrcB.
REQ-008 SHALL have port busy, output, 1 bit: operation in flight; the controller stalls the PC while it is high.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-010 SHALL have port result, output, 32 bits: packed single result, feeding the FP leg of the result selector.
REQ-011 SHALL have port flags, output, 4 bits {N,Z,C,V}: N = result sign, Z = result is +/-0, C = 0 always, V = overflow to infinity.

Function
REQ-012 SHALL implement the FSM IDLE -> UNPACK -> EXEC -> NORM -> PACK -> IDLE.
REQ-013 SHALL, in IDLE with start=1, register a, b and op at that edge, and set busy=1 from the next cycle.
REQ-014 SHALL spend exactly 1 cycle in EXEC for add, and exactly 24/MUL_K cycles in EXEC for multiply, counted by an iteration counter.
REQ-015 SHALL produce latency N, measured from the start edge to the cycle in which done=1: N = 4 for add, N = 24/MUL_K + 3 for multiply; the default multiply latency is 27.
REQ-016 SHALL, in the done cycle, assert done=1 and busy=0 with result and flags valid; result and flags SHALL then hold until the next accepted start.
REQ-017 SHALL ignore start while busy=1; no queuing is performed.
REQ-018 SHALL accept start in the same cycle as done, since the FSM is in IDLE in that cycle.
REQ-019 SHALL, for add, align the smaller-exponent significand with a barrel shift and OR shifted-out bits into a sticky bit; shifts of 26 or more SHALL yield sticky only.
REQ-020 SHALL, for multiply, form a 48-bit significand product by shift-add with MUL_K bits per iteration; exponent = ea + eb - 127.
REQ-021 SHALL round toward zero (truncate) in all cases.
REQ-022 SHALL flush denormal inputs to signed zero, and flush results below the normal range to +0 with Z=1.
REQ-023 SHALL, on exponent overflow, return signed infinity with V=1.
REQ-024 SHALL return the canonical NaN 32'h7FC00000 with N=0 for any NaN input, Inf*0, or Inf + (-Inf).
REQ-025 SHALL return +0 for exact cancellation in add.
REQ-026 SHALL return Inf op finite per IEEE sign rules.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, busy=0, done=0, result=32'h0, flags=4'b0100, and clear the iteration counter.
REQ-028 SHALL, on reset asserted mid-operation, abort immediately; no done pulse SHALL follow the release of reset.

Structure
REQ-029 SHALL take from shared package fp_pkg: the FSM state enum, the field widths (EXP_W=8, MAN_W=23, BIAS=127), and the constants QNAN=32'h7FC00000 and POS_INF=32'h7F800000.
REQ-030 SHALL instantiate one sub-module, fp_lzc: a 48-bit leading-zero counter used by the NORM state.

Verification
REQ-031 SHALL be verified by: add a=3F800000, b=40000000 -> result 40400000, flags 0000, done exactly 4 cycles after the start edge.
REQ-032 SHALL be verified by: mul a=3FC00000, b=40000000, MUL_K=1 -> result 40400000, done after 27 cycles; the same stimulus with MUL_K=4 -> done after 9 cycles.
REQ-033 SHALL be verified by: add 3F800000 + BF800000 -> result 00000000, flags 0100; mul 7F800000 * 00000000 -> result 7FC00000.
REQ-034 SHALL be verified by: mul 7F000000 * 7F000000 -> result 7F800000, flags 0001; mul FF000000 * 7F000000 -> result FF800000, flags 1001.
REQ-035 SHALL be verified by: start a second operation while busy -> no effect; the first operation completes with its own result and exactly one done pulse.
REQ-036 SHALL be verified by: pulse reset=0 at cycle 10 of a multiply -> busy=0, result=0 immediately, and no done pulse for the aborted operation.
